// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between uart_rx and sobel_applier: parses a W/H header,
// forwards W*H pixel bytes, counts processed bytes and reports frame status.
module sobel_frame_ctrl #(
  parameter int MAX_WIDTH      = 1024,
  parameter int MAX_HEIGHT     = 1024,
  parameter int CNT_W          = 20,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  input  logic        out_valid,
  input  logic        out_ready,
  output logic        sobel_clr,
  output logic [15:0] frame_width,
  output logic [15:0] frame_height,
  output logic        cfg_valid,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err
);

  // A full MAX_WIDTH x MAX_HEIGHT frame (1024*1024 = 2^20) needs one bit more
  // than CNT_W=20 gives, so the counters widen to whichever is larger.
  localparam int AREA_W = $clog2(MAX_WIDTH * MAX_HEIGHT + 1);
  localparam int PIX_W  = (CNT_W > AREA_W) ? CNT_W : AREA_W;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      MAX_W16 = 16'(MAX_WIDTH);
  localparam logic [15:0]      MAX_H16 = 16'(MAX_HEIGHT);
  localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);
  localparam logic [PIX_W-1:0] PIX_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE, HDR, CHECK, STREAM, DRAIN, DONE, ABORT
  } state_t;

  state_t            state;
  logic [1:0]        hdr_idx;
  logic [31:0]       hdr;
  logic [PIX_W-1:0]  in_cnt;
  logic [PIX_W-1:0]  out_cnt;
  logic [PIX_W-1:0]  rx_left;
  logic [TO_W-1:0]   idle_cnt;

  logic [15:0]       hdr_w;
  logic [15:0]       hdr_h;
  logic [PIX_W-1:0]  area;
  logic              dims_bad;
  logic              handshake;
  logic              out_beat;
  logic              overrun_hit;
  logic              timeout_hit;

  assign hdr_w       = hdr[15:0];
  assign hdr_h       = hdr[31:16];
  assign area        = PIX_W'(hdr_w) * PIX_W'(hdr_h);
  assign dims_bad    = (hdr_w == 16'd0) || (hdr_h == 16'd0) ||
                       (hdr_w > MAX_W16) || (hdr_h > MAX_H16);
  assign handshake   = pix_valid && pix_ready;
  assign out_beat    = out_valid && out_ready;
  assign overrun_hit = rx_valid && pix_valid && !pix_ready;
  assign timeout_hit = !rx_valid && (idle_cnt == TO_LAST);
  assign busy        = (state != IDLE);

  // rx_left gates acceptance so no more than W*H bytes ever reach the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hdr_idx      <= 2'd0;
      hdr          <= 32'd0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      rx_left      <= '0;
      idle_cnt     <= '0;
      pix_data     <= 8'd0;
      pix_valid    <= 1'b0;
      sobel_clr    <= 1'b0;
      frame_width  <= 16'd0;
      frame_height <= 16'd0;
      cfg_valid    <= 1'b0;
      done         <= 1'b0;
      err          <= 3'b000;
    end else begin
      cfg_valid <= 1'b0;
      done      <= 1'b0;
      sobel_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            hdr[7:0] <= rx_data;
            hdr_idx  <= 2'd1;
            idle_cnt <= '0;
            state    <= HDR;
          end
        end
        HDR: begin
          if (rx_valid) begin
            case (hdr_idx)
              2'd1:    hdr[15:8]  <= rx_data;
              2'd2:    hdr[23:16] <= rx_data;
              2'd3:    hdr[31:24] <= rx_data;
              default: hdr[7:0]   <= rx_data;
            endcase
            hdr_idx  <= hdr_idx + 2'd1;
            idle_cnt <= '0;
            if (hdr_idx == 2'd3) state <= CHECK;
          end else if (timeout_hit) begin
            err[2]    <= 1'b1;
            sobel_clr <= 1'b1;
            state     <= ABORT;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (dims_bad) begin
            err[0]    <= 1'b1;
            sobel_clr <= 1'b1;
            state     <= ABORT;
          end else begin
            err          <= 3'b000;
            cfg_valid    <= 1'b1;
            frame_width  <= hdr_w;
            frame_height <= hdr_h;
            in_cnt       <= area;
            out_cnt      <= area;
            rx_left      <= area;
            state        <= STREAM;
          end
        end
        STREAM: begin
          if (out_beat && out_cnt != PIX_ZERO) out_cnt <= out_cnt - 1'b1;
          if (overrun_hit) begin
            err[1]    <= 1'b1;
            pix_valid <= 1'b0;
            sobel_clr <= 1'b1;
            state     <= ABORT;
          end else if (timeout_hit) begin
            err[2]    <= 1'b1;
            pix_valid <= 1'b0;
            sobel_clr <= 1'b1;
            state     <= ABORT;
          end else begin
            idle_cnt <= rx_valid ? '0 : idle_cnt + 1'b1;
            if (rx_valid && rx_left != PIX_ZERO) begin
              pix_data  <= rx_data;
              pix_valid <= 1'b1;
              rx_left   <= rx_left - 1'b1;
            end else if (handshake) begin
              pix_valid <= 1'b0;
            end
            if (handshake) begin
              in_cnt <= in_cnt - 1'b1;
              if (in_cnt == PIX_ONE) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_beat && out_cnt != PIX_ZERO) out_cnt <= out_cnt - 1'b1;
          if (out_cnt == PIX_ZERO) begin
            done      <= 1'b1;
            sobel_clr <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ABORT: begin
          pix_valid <= 1'b0;
          in_cnt    <= '0;
          out_cnt   <= '0;
          rx_left   <= '0;
          idle_cnt  <= '0;
          hdr_idx   <= 2'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: header table, full frames, overrun,
// timeout and mid-frame reset.
module tb_sobel_frame_ctrl;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        pix_ready = 1'b0;
  logic        out_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        sobel_clr;
  logic [15:0] frame_width;
  logic [15:0] frame_height;
  logic        cfg_valid;
  logic        busy;
  logic        done;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int cfg_cnt = 0;
  int done_cnt = 0;
  int clr_cnt = 0;
  logic [7:0] pix_q[$];

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic        exp_cfg;
    logic [2:0]  exp_err;
    logic [15:0] exp_w, exp_h;
    int          exp_cnt;
  } hdr_vec_t;

  hdr_vec_t vecs[9];

  sobel_frame_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .sobel_clr(sobel_clr),
    .frame_width(frame_width), .frame_height(frame_height),
    .cfg_valid(cfg_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Negedge sampling sees the same values the next posedge will capture.
  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      hs_cnt++;
      pix_q.push_back(pix_data);
    end
    if (cfg_valid) cfg_cnt++;
    if (done) done_cnt++;
    if (sobel_clr) clr_cnt++;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic sendHeader(input logic [7:0] b0, b1, b2, b3);
    applyStimulus(b0, 0);
    applyStimulus(b1, 0);
    applyStimulus(b2, 0);
    applyStimulus(b3, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] pixVal(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic runFrame(input string tag);
    int hs0, done0, cfg0, clr0, q0;
    hs0 = hs_cnt; done0 = done_cnt; cfg0 = cfg_cnt; clr0 = clr_cnt; q0 = pix_q.size();
    pix_ready = 1'b1;
    sendHeader(8'd5, 8'd0, 8'd7, 8'd0);
    checkOutput({tag, "_cfg_early"}, 32'(cfg_valid), 0);
    tick();
    checkOutput({tag, "_cfg"}, 32'(cfg_valid), 1);
    checkOutput({tag, "_width"}, 32'(frame_width), 5);
    checkOutput({tag, "_height"}, 32'(frame_height), 7);
    checkOutput({tag, "_err_cfg"}, 32'(err), 0);
    checkOutput({tag, "_busy_cfg"}, 32'(busy), 1);
    // First 10 pixels carry a real output beat, next 5 a beat without ready;
    // pixels 20..25 arrive back-to-back so rx meets a completing handshake.
    for (int i = 0; i < 35; i++) begin
      out_valid = (i < 15);
      out_ready = (i < 10);
      applyStimulus(pixVal(i), 0);
      out_valid = 1'b0;
      out_ready = 1'b0;
      repeat ((i >= 20 && i < 25) ? 0 : 3) tick();
    end
    checkOutput({tag, "_hs_count"}, 32'(hs_cnt - hs0), 35);
    checkOutput({tag, "_busy_drain"}, 32'(busy), 1);
    applyStimulus(8'hEE, 2);
    checkOutput({tag, "_drain_ignore_hs"}, 32'(hs_cnt - hs0), 35);
    checkOutput({tag, "_drain_ignore_pv"}, 32'(pix_valid), 0);
    for (int i = 0; i < 35; i++)
      checkOutput({tag, "_pix_data"}, 32'(pix_q[q0 + i]), 32'(pixVal(i)));
    out_valid = 1'b1;
    out_ready = 1'b1;
    repeat (24) tick();
    out_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    checkOutput({tag, "_no_early_done"}, 32'(done_cnt - done0), 0);
    checkOutput({tag, "_busy_34"}, 32'(busy), 1);
    out_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, "_done_lat0"}, 32'(done), 0);
    tick();
    checkOutput({tag, "_done"}, 32'(done), 1);
    checkOutput({tag, "_clr_done"}, 32'(sobel_clr), 1);
    tick();
    checkOutput({tag, "_done_off"}, 32'(done), 0);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 0);
    checkOutput({tag, "_err_end"}, 32'(err), 0);
    checkOutput({tag, "_done_once"}, 32'(done_cnt - done0), 1);
    checkOutput({tag, "_cfg_once"}, 32'(cfg_cnt - cfg0), 1);
    checkOutput({tag, "_clr_once"}, 32'(clr_cnt - clr0), 1);
  endtask

  initial begin
    int hs0;
    vecs[0] = '{8'h00, 8'h00, 8'h07, 8'h00, 1'b0, 3'b001, 16'd0, 16'd0, 0};
    vecs[1] = '{8'h05, 8'h00, 8'h07, 8'h00, 1'b1, 3'b000, 16'd5, 16'd7, 35};
    vecs[2] = '{8'h01, 8'h04, 8'h01, 8'h04, 1'b0, 3'b001, 16'd0, 16'd0, 0};
    vecs[3] = '{8'h00, 8'h04, 8'h00, 8'h04, 1'b1, 3'b000, 16'd1024, 16'd1024, 1048576};
    vecs[4] = '{8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 3'b001, 16'd0, 16'd0, 0};
    vecs[5] = '{8'h01, 8'h04, 8'h00, 8'h04, 1'b0, 3'b001, 16'd0, 16'd0, 0};
    vecs[6] = '{8'h00, 8'h04, 8'h01, 8'h04, 1'b0, 3'b001, 16'd0, 16'd0, 0};
    vecs[7] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 3'b001, 16'd0, 16'd0, 0};
    vecs[8] = '{8'h03, 8'h00, 8'h03, 8'h00, 1'b1, 3'b000, 16'd3, 16'd3, 9};

    $display("[TB] reset state");
    repeat (3) tick();
    checkOutput("rst_pix_data", 32'(pix_data), 0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 0);
    checkOutput("rst_sobel_clr", 32'(sobel_clr), 0);
    checkOutput("rst_width", 32'(frame_width), 0);
    checkOutput("rst_height", 32'(frame_height), 0);
    checkOutput("rst_cfg", 32'(cfg_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    rst = 1'b0;
    tick();

    $display("[TB] 5x7 frame");
    runFrame("frame1");

    $display("[TB] header table");
    pix_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      sendHeader(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3);
      tick();
      checkOutput("hdr_cfg", 32'(cfg_valid), 32'(vecs[v].exp_cfg));
      checkOutput("hdr_err", 32'(err), 32'(vecs[v].exp_err));
      checkOutput("hdr_clr", 32'(sobel_clr), 32'(!vecs[v].exp_cfg));
      checkOutput("hdr_busy", 32'(busy), 1);
      checkOutput("hdr_pix_valid", 32'(pix_valid), 0);
      if (vecs[v].exp_cfg) begin
        checkOutput("hdr_width", 32'(frame_width), 32'(vecs[v].exp_w));
        checkOutput("hdr_height", 32'(frame_height), 32'(vecs[v].exp_h));
        checkOutput("hdr_in_cnt", 32'(dut.in_cnt), 32'(vecs[v].exp_cnt));
      end
      tick();
      checkOutput("hdr_busy_after", 32'(busy), 32'(vecs[v].exp_cfg));
      if (vecs[v].exp_cfg) doReset();
    end

    $display("[TB] overrun");
    hs0 = hs_cnt;
    pix_ready = 1'b0;
    sendHeader(8'd3, 8'd0, 8'd3, 8'd0);
    tick();
    checkOutput("ovr_cfg", 32'(cfg_valid), 1);
    applyStimulus(8'h11, 1);
    checkOutput("ovr_pv_stall", 32'(pix_valid), 1);
    applyStimulus(8'h22, 0);
    checkOutput("ovr_err", 32'(err), 3'b010);
    checkOutput("ovr_clr", 32'(sobel_clr), 1);
    checkOutput("ovr_pv_drop", 32'(pix_valid), 0);
    checkOutput("ovr_busy_abort", 32'(busy), 1);
    applyStimulus(8'h33, 0);
    checkOutput("ovr_busy_idle", 32'(busy), 0);
    checkOutput("ovr_pv_idle", 32'(pix_valid), 0);
    tick();
    checkOutput("ovr_ignored", 32'(busy), 0);
    checkOutput("ovr_no_hs", 32'(hs_cnt - hs0), 0);
    sendHeader(8'd3, 8'd0, 8'd3, 8'd0);
    tick();
    checkOutput("ovr_next_cfg", 32'(cfg_valid), 1);
    checkOutput("ovr_next_err", 32'(err), 0);
    doReset();
    pix_ready = 1'b1;

    $display("[TB] timeout");
    applyStimulus(8'd5, 0);
    applyStimulus(8'd0, 0);
    repeat (TO - 1) tick();
    checkOutput("to_err_before", 32'(err), 0);
    checkOutput("to_busy_before", 32'(busy), 1);
    tick();
    checkOutput("to_err", 32'(err), 3'b100);
    checkOutput("to_clr", 32'(sobel_clr), 1);
    tick();
    checkOutput("to_busy_idle", 32'(busy), 0);
    checkOutput("to_err_sticky", 32'(err), 3'b100);

    $display("[TB] reset mid-stream");
    sendHeader(8'd5, 8'd0, 8'd7, 8'd0);
    tick();
    for (int i = 0; i < 9; i++) applyStimulus(pixVal(i), 2);
    applyStimulus(pixVal(9), 0);
    checkOutput("mid_pv_live", 32'(pix_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_pix_valid", 32'(pix_valid), 0);
    checkOutput("mid_pix_data", 32'(pix_data), 0);
    checkOutput("mid_busy", 32'(busy), 0);
    checkOutput("mid_width", 32'(frame_width), 0);
    checkOutput("mid_height", 32'(frame_height), 0);
    checkOutput("mid_err", 32'(err), 0);
    checkOutput("mid_cfg", 32'(cfg_valid), 0);
    checkOutput("mid_done", 32'(done), 0);
    checkOutput("mid_clr", 32'(sobel_clr), 0);
    tick();
    rst = 1'b0;
    tick();
    runFrame("frame2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
